// File: rtl/decode_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions for the MIPS decode stage.
package decode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   // ALUOp is {ALUOp1, ALUOp0}
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       regDst;
      logic       aluSrc;
      logic       memToReg;
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic       branch;
      logic [1:0] aluOp;
   } ctrlT;

   // Unknown opcodes decode to an all-zero bundle, which behaves as a NOP.
   function automatic ctrlT decodeOpcode(input logic [5:0] opcode);
      ctrlT ctrl;
      ctrl = '0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.regDst   = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.aluOp    = ALUOP_FUNCT;
         end
         OP_LW: begin
            ctrl.aluSrc   = 1'b1;
            ctrl.memToReg = 1'b1;
            ctrl.regWrite = 1'b1;
            ctrl.memRead  = 1'b1;
            ctrl.aluOp    = ALUOP_ADD;
         end
         OP_SW: begin
            ctrl.aluSrc   = 1'b1;
            ctrl.memWrite = 1'b1;
            ctrl.aluOp    = ALUOP_ADD;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.aluOp  = ALUOP_SUB;
         end
         default: ctrl = '0;
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: async reset, two combinational read ports, one write port, r0 hardwired.
// Optional same-cycle write-to-read forwarding when DECODE_WRITE_BYPASS_EN is defined.
module reg_file
   import decode_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  readReg1,
   input  logic [4:0]  readReg2,
   input  logic [4:0]  writeReg,
   input  logic [31:0] writeData,
   input  logic        writeEn,
   output logic [31:0] readData1,
   output logic [31:0] readData2
);

   logic [31:0] regs [32];
   logic        doWrite;

   assign doWrite = writeEn && (writeReg != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (doWrite) begin
         regs[writeReg] <= writeData;
      end
   end

   always_comb begin
      readData1 = (readReg1 == 5'd0) ? 32'd0 : regs[readReg1];
      readData2 = (readReg2 == 5'd0) ? 32'd0 : regs[readReg2];
`ifdef DECODE_WRITE_BYPASS_EN
      // Reset blocks writes, so it must block the forwarded value as well.
      if (doWrite && !rst && (writeReg == readReg1)) readData1 = writeData;
      if (doWrite && !rst && (writeReg == readReg2)) readData2 = writeData;
`endif
   end

endmodule

// File: rtl/decode_module.sv
// MIPS instruction-decode stage: main control, register-file reads, sign-extend, rt/rd fields.
// Define DECODE_WRITE_BYPASS_EN to forward the WB write to the read ports in the same cycle.
module decode_module
   import decode_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   input  logic [4:0]  writeRegister,
   input  logic [31:0] writeData,
   input  logic        RegWrite_in,
   output logic        RegDst,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        Branch,
   output logic        ALUOp1,
   output logic        ALUOp0,
   output logic        RegWrite,
   output logic [31:0] ReadData1,
   output logic [31:0] ReadData2,
   output logic [31:0] signExtended,
   output logic [4:0]  instruction_20_16,
   output logic [4:0]  instruction_15_11
);

   ctrlT ctrl;

   always_comb begin
      ctrl = decodeOpcode(instruction[31:26]);
   end

   assign RegDst   = ctrl.regDst;
   assign ALUSrc   = ctrl.aluSrc;
   assign MemtoReg = ctrl.memToReg;
   assign MemRead  = ctrl.memRead;
   assign MemWrite = ctrl.memWrite;
   assign Branch   = ctrl.branch;
   assign ALUOp1   = ctrl.aluOp[1];
   assign ALUOp0   = ctrl.aluOp[0];
   assign RegWrite = ctrl.regWrite;

   assign signExtended      = {{16{instruction[15]}}, instruction[15:0]};
   assign instruction_20_16 = instruction[20:16];
   assign instruction_15_11 = instruction[15:11];

   reg_file uRegFile (
      .clk       (clk),
      .rst       (rst),
      .readReg1  (instruction[25:21]),
      .readReg2  (instruction[20:16]),
      .writeReg  (writeRegister),
      .writeData (writeData),
      .writeEn   (RegWrite_in),
      .readData1 (ReadData1),
      .readData2 (ReadData2)
   );

endmodule

// File: tb/tb_decode_module.sv
// Self-checking bench for decode_module: table-driven decode vectors plus a register-file scoreboard.
module tb_decode_module;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;
   logic        RegWrite_in;
   logic        RegDst, ALUSrc, MemtoReg, MemRead, MemWrite, Branch, ALUOp1, ALUOp0, RegWrite;
   logic [31:0] ReadData1, ReadData2, signExtended;
   logic [4:0]  instruction_20_16, instruction_15_11;

   always #5 clk = ~clk;

   decode_module dut (
      .clk               (clk),
      .rst               (rst),
      .instruction       (instruction),
      .writeRegister     (writeRegister),
      .writeData         (writeData),
      .RegWrite_in       (RegWrite_in),
      .RegDst            (RegDst),
      .ALUSrc            (ALUSrc),
      .MemtoReg          (MemtoReg),
      .MemRead           (MemRead),
      .MemWrite          (MemWrite),
      .Branch            (Branch),
      .ALUOp1            (ALUOp1),
      .ALUOp0            (ALUOp0),
      .RegWrite          (RegWrite),
      .ReadData1         (ReadData1),
      .ReadData2         (ReadData2),
      .signExtended      (signExtended),
      .instruction_20_16 (instruction_20_16),
      .instruction_15_11 (instruction_15_11)
   );

   // Order: RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0
   logic [8:0] ctrlVec;
   assign ctrlVec = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp1, ALUOp0};

   typedef struct {
      logic [31:0] instr;
      logic [8:0]  expCtrl;
      logic [31:0] expSext;
      logic [4:0]  expRt;
      logic [4:0]  expRd;
   } vecT;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] value;
   } sbT;

   int nTests = 0;
   int nFail  = 0;
   vecT vecs [8];
   sbT  sbQ [$];
   logic [31:0] model [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{32'hAC010600, 9'b010001000, 32'h00000600, 5'd1, 5'd0};
      vecs[1] = '{32'h00010600, 9'b100100010, 32'h00000600, 5'd1, 5'd0};
      vecs[2] = '{32'h8C22FFFC, 9'b011110000, 32'hFFFFFFFC, 5'd2, 5'd31};
      vecs[3] = '{32'h10220003, 9'b000000101, 32'h00000003, 5'd2, 5'd0};
      vecs[4] = '{32'h20228000, 9'b000000000, 32'hFFFF8000, 5'd2, 5'd16};
      vecs[5] = '{32'hFC007FFF, 9'b000000000, 32'h00007FFF, 5'd0, 5'd15};
      vecs[6] = '{32'h8C000000, 9'b011110000, 32'h00000000, 5'd0, 5'd0};
      vecs[7] = '{32'h04000000, 9'b000000000, 32'h00000000, 5'd0, 5'd0};
      for (int i = 0; i < 32; i++) model[i] = '0;

      rst = 1'b1;
      instruction = 32'hAC010600;
      writeRegister = '0;
      writeData = '0;
      RegWrite_in = 1'b0;
      #12;
      check("reset ReadData1", ReadData1, 32'd0);
      check("reset ReadData2", ReadData2, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Combinational decode table
      for (int i = 0; i < 8; i++) begin
         instruction = vecs[i].instr;
         #1;
         check($sformatf("ctrl[%0d]", i), 32'(ctrlVec), 32'(vecs[i].expCtrl));
         check($sformatf("sext[%0d]", i), signExtended, vecs[i].expSext);
         check($sformatf("rt[%0d]", i), 32'(instruction_20_16), 32'(vecs[i].expRt));
         check($sformatf("rd[%0d]", i), 32'(instruction_15_11), 32'(vecs[i].expRd));
      end

      // Write to r0 is dropped
      @(negedge clk);
      instruction = 32'h00010600;
      writeRegister = 5'd0; writeData = 32'd1; RegWrite_in = 1'b1;
      @(posedge clk); #1;
      instruction = 32'h00000000;
      #1;
      check("r0 protected", ReadData1, 32'd0);

      // r1 = 2, then a disabled write must not change it
      @(negedge clk);
      instruction = 32'h00010600;
      writeRegister = 5'd1; writeData = 32'd2; RegWrite_in = 1'b1;
      @(posedge clk); #1;
      RegWrite_in = 1'b0; writeData = 32'd5;
      #1;
      check("r1 write", ReadData2, 32'd2);
      @(posedge clk); #1;
      check("r1 no-enable hold", ReadData2, 32'd2);
      model[1] = 32'd2;

      // Scoreboarded random writes; rs reads the new entry, rt an older one
      for (int i = 0; i < 12; i++) begin
         logic [4:0]  idx;
         logic [4:0]  other;
         logic [31:0] val;
         sbT          got;
         @(negedge clk);
         idx = 5'($urandom_range(0, 31));
         other = 5'($urandom_range(0, 31));
         val = $urandom;
         writeRegister = idx; writeData = val; RegWrite_in = 1'b1;
         if (idx != 5'd0) model[idx] = val;
         sbQ.push_back('{idx, model[idx]});
         @(posedge clk); #1;
         RegWrite_in = 1'b0;
         if (sbQ.size() == 0) begin
            check("scoreboard empty", 32'd0, 32'd1);
         end else begin
            got = sbQ.pop_front();
            instruction = {6'b000000, got.idx, other, 16'h0000};
            #1;
            check($sformatf("sb rs r%0d", got.idx), ReadData1, got.value);
            check($sformatf("sb rt r%0d", other), ReadData2, model[other]);
         end
      end

      // Same-cycle write/read on rt=1: bypass shows it before the edge
      @(negedge clk);
      instruction = 32'h00010600;
      writeRegister = 5'd1; writeData = 32'd7; RegWrite_in = 1'b1;
      #1;
`ifdef DECODE_WRITE_BYPASS_EN
      check("bypass before edge", ReadData2, 32'd7);
`else
      check("no bypass before edge", ReadData2, model[1]);
`endif
      @(posedge clk); #1;
      RegWrite_in = 1'b0;
      model[1] = 32'd7;
      #1;
      check("r1 after edge", ReadData2, 32'd7);

      // Async reset mid-cycle wipes r5; writes during reset are dropped
      @(negedge clk);
      writeRegister = 5'd5; writeData = 32'hDEADBEEF; RegWrite_in = 1'b1;
      @(posedge clk); #1;
      RegWrite_in = 1'b0;
      instruction = {6'b000000, 5'd5, 5'd1, 16'h0000};
      #1;
      check("r5 written", ReadData1, 32'hDEADBEEF);
      #1;
      rst = 1'b1;
      #1;
      check("r5 async reset", ReadData1, 32'd0);
      check("r1 async reset", ReadData2, 32'd0);
      writeRegister = 5'd5; writeData = 32'h12345678; RegWrite_in = 1'b1;
      #1;
      check("bypass blocked in reset", ReadData1, 32'd0);
      @(posedge clk); #1;
      check("write dropped in reset", ReadData1, 32'd0);
      @(negedge clk);
      RegWrite_in = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      check("r5 after reset release", ReadData1, 32'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
